match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win; legal 1..15.
REQ-002 SHALL have parameter SERVE_DELAY, default 60, frame ticks the ball waits before each serve; legal 1..255.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, game running; 0 = paused.
REQ-006 SHALL have port clear, input, 1, synchronous request to abandon the match and zero the scores.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-008 SHALL have port miss_left, input, 1, one-cycle pulse: ball passed the left paddle.
REQ-009 SHALL have port miss_right, input, 1, one-cycle pulse: ball passed the right paddle.
REQ-010 SHALL have port score_left, output, 4, left player score.
REQ-011 SHALL have port score_right, output, 4, right player score.
REQ-012 SHALL have port ball_run, output, 1, ball motion enable.
REQ-013 SHALL have port ball_reset, output, 1, one-cycle pulse to recentre the ball.
REQ-014 SHALL have port serve_dir, output, 1, serve direction: 0 = toward left, 1 = toward right.
REQ-015 SHALL have port game_over, output, 1, match finished.
REQ-016 SHALL have port winner, output, 1, 0 = left won, 1 = right won; meaningful only while game_over=1.

Function
REQ-017 SHALL implement the states IDLE, SERVE, RALLY, POINT and OVER, all registered.
REQ-018 SHALL, in IDLE, hold ball_run=0; when enable=1, move to SERVE, pulse ball_reset and load the serve counter with SERVE_DELAY.
REQ-019 SHALL, in SERVE, hold ball_run=0 and decrement the serve counter on each frame_tick while enable=1.
REQ-020 SHALL, in SERVE, move to RALLY in the cycle after the serve counter reaches 0.
REQ-021 SHALL, in RALLY, drive ball_run=enable.
REQ-022 SHALL, in RALLY with enable=1, treat miss_left as a point to the right player and miss_right as a point to the left player: increment that score and enter POINT.
REQ-023 SHALL, when miss_left and miss_right are both high in the same cycle, award no point, pulse ball_reset, reload the counter, return to SERVE and leave serve_dir unchanged.
REQ-024 SHALL set serve_dir on each point toward the player who conceded: miss_left gives 0, miss_right gives 1.
REQ-025 SHALL, in POINT (one cycle), go to OVER with winner set to the scorer if the scorer's score equals WIN_SCORE; otherwise pulse ball_reset, reload the counter and go to SERVE.
REQ-026 SHALL, in OVER, hold game_over=1, ball_run=0, and freeze the scores and winner until clear.
REQ-027 SHALL ignore miss_left/miss_right outside RALLY and while enable=0.
REQ-028 SHALL ignore frame_tick while enable=0 (pause freezes the serve counter).
REQ-029 SHALL saturate the scores at 15 and never wrap.
REQ-030 SHALL give clear priority over all other inputs in every state: next cycle IDLE, scores 0, serve_dir 0, game_over 0, winner 0, ball_reset pulsed once.
REQ-031 SHALL assert ball_reset for exactly one cycle per event, never two consecutive cycles.
REQ-032 SHALL, if a frame_tick coincides with the counter load, ignore that tick so the wait is a full SERVE_DELAY ticks.

Reset
REQ-033 SHALL, when reset=0, immediately force: state IDLE, score_left=0, score_right=0, serve counter 0, ball_run=0, ball_reset=0, serve_dir=0, game_over=0, winner=0.
REQ-034 SHALL abort any match when reset asserts mid-operation, with no point awarded and no ball_reset pulse on release.
REQ-035 SHALL start acting on inputs from the first rising clock edge after reset deasserts.

Verification (WIN_SCORE=3, SERVE_DELAY=2)
REQ-036 SHALL be checked for serve timing: reset release, then enable=1 -> one ball_reset pulse; ball_run rises the cycle after the 2nd frame_tick.
REQ-037 SHALL be checked for scoring: in RALLY, pulse miss_right -> score_left=1, serve_dir=1, ball_run=0, ball_reset pulse, re-serve after 2 ticks.
REQ-038 SHALL be checked for a win: three miss_left points -> score_right=3, game_over=1, winner=1; further misses and ticks change nothing.
REQ-039 SHALL be checked for pause: enable=0 during SERVE with 4 frame_ticks -> counter frozen; on resume, 2 ticks still needed; a miss_left during pause leaves the scores unchanged.
REQ-040 SHALL be checked for a simultaneous miss: miss_left and miss_right in the same cycle -> scores unchanged, ball_reset pulse, back to SERVE.
REQ-041 SHALL be checked for clear and reset mid-match: clear in OVER with score 3-1 -> IDLE, scores 0-0; reset=0 in RALLY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/match_ctrl.sv
// Match sequencer for a two-player paddle game: serve countdown, rally, point
// scoring with saturation, and the match-over hold until cleared.
module match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        RALLY,
        POINT,
        OVER
    } state_t;

    localparam logic [7:0] DELAY = 8'(SERVE_DELAY);
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [3:0] score_left_q, score_left_d;
    logic [3:0] score_right_q, score_right_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ball_reset_q, ball_reset_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       scorer_q, scorer_d;
    logic       recentre;

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        cnt_d         = cnt_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        scorer_d      = scorer_q;
        recentre      = 1'b0;

        if (clear) begin
            state_d       = IDLE;
            score_left_d  = '0;
            score_right_d = '0;
            cnt_d         = '0;
            serve_dir_d   = 1'b0;
            winner_d      = 1'b0;
            recentre      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d  = SERVE;
                        cnt_d    = DELAY;
                        recentre = 1'b1;
                    end
                end
                SERVE: begin
                    // Leave on the tick that empties the counter so the ball
                    // moves in the cycle right after it reaches zero.
                    if (cnt_q == '0) begin
                        state_d = RALLY;
                    end else if (enable && frame_tick) begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = RALLY;
                        end
                    end
                end
                RALLY: begin
                    if (enable) begin
                        if (miss_left && miss_right) begin
                            state_d  = SERVE;
                            cnt_d    = DELAY;
                            recentre = 1'b1;
                        end else if (miss_left) begin
                            score_right_d = (score_right_q == 4'hF) ? score_right_q : score_right_q + 4'd1;
                            serve_dir_d   = 1'b0;
                            scorer_d      = 1'b1;
                            state_d       = POINT;
                        end else if (miss_right) begin
                            score_left_d = (score_left_q == 4'hF) ? score_left_q : score_left_q + 4'd1;
                            serve_dir_d  = 1'b1;
                            scorer_d     = 1'b0;
                            state_d      = POINT;
                        end
                    end
                end
                POINT: begin
                    if (scorer_q ? (score_right_q == WIN) : (score_left_q == WIN)) begin
                        state_d  = OVER;
                        winner_d = scorer_q;
                    end else begin
                        state_d  = SERVE;
                        cnt_d    = DELAY;
                        recentre = 1'b1;
                    end
                end
                OVER: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Back-to-back recentre requests collapse into a single pulse.
        ball_reset_d = recentre && !ball_reset_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            cnt_q         <= '0;
            ball_reset_q  <= 1'b0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            scorer_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            cnt_q         <= cnt_d;
            ball_reset_q  <= ball_reset_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            scorer_q      <= scorer_d;
        end
    end

    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign ball_run    = (state_q == RALLY) && enable;
    assign ball_reset  = ball_reset_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = (state_q == OVER);
    assign winner      = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: stimulus queues the expected output vector
// and cycle of every output change; a negedge monitor pops and compares.
module tb_match_ctrl;

    localparam int WIN = 3;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       frame_tick;
    logic       miss_left;
    logic       miss_right;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    match_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .frame_tick (frame_tick),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .score_left (score_left),
        .score_right(score_right),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Vector layout: {game_over, winner, serve_dir, ball_run, ball_reset, score_left, score_right}
    logic       m_go, m_w, m_sd, m_br, m_brs;
    logic [3:0] m_sl, m_sr;

    function automatic logic [12:0] model_vec();
        return {m_go, m_w, m_sd, m_br, m_brs, m_sl, m_sr};
    endfunction

    task automatic expect_in(input int dt);
        exp_t e;
        e.cyc = cyc + dt;
        e.v   = model_vec();
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    logic [12:0] mon_prev;
    logic [12:0] mon_vec;
    bit          mon_first = 1'b1;
    exp_t        mon_e;

    always @(negedge clock) begin
        mon_vec = {game_over, winner, serve_dir, ball_run, ball_reset, score_left, score_right};
        if (mon_first || mon_vec !== mon_prev) begin
            mon_first = 1'b0;
            mon_prev  = mon_vec;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, mon_vec);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.v !== mon_vec || mon_e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL output_event got=%h at cyc %0d required=%h at cyc %0d",
                             mon_vec, cyc, mon_e.v, mon_e.cyc);
                end
            end
        end
    end

    // Counter is full and ball_reset already low: two ticks, ball moves after the second.
    task automatic serve_ticks();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        frame_tick = 1'b1;
        m_br = 1'b1;
        expect_in(1);
        step();
        frame_tick = 1'b0;
    endtask

    task automatic point(input bit left_misses);
        if (left_misses) begin
            miss_left = 1'b1;
            if (m_sr != 4'hF) m_sr = m_sr + 4'd1;
            m_sd = 1'b0;
        end else begin
            miss_right = 1'b1;
            if (m_sl != 4'hF) m_sl = m_sl + 4'd1;
            m_sd = 1'b1;
        end
        m_br = 1'b0;
        expect_in(1);
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        if ((left_misses ? m_sr : m_sl) == 4'(WIN)) begin
            m_go = 1'b1;
            m_w  = left_misses;
            expect_in(1);
            step();
        end else begin
            m_brs = 1'b1;
            expect_in(1);
            step();
            m_brs = 1'b0;
            expect_in(1);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish before timeout", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0;
        frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        m_go = 0; m_w = 0; m_sd = 0; m_br = 0; m_brs = 0; m_sl = '0; m_sr = '0;
        expect_in(1);
        step();
        step();
        reset = 1'b1;
        step();

        // First serve; the tick coinciding with the counter load is ignored.
        enable     = 1'b1;
        frame_tick = 1'b1;
        m_brs      = 1'b1;
        expect_in(1);
        step();
        frame_tick = 1'b0;
        m_brs      = 1'b0;
        expect_in(1);
        step();
        serve_ticks();

        point(1'b0);
        serve_ticks();

        // Pause during rally: ball stops, a miss is ignored.
        enable = 1'b0;
        m_br   = 1'b0;
        expect_in(1);
        step();
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        enable    = 1'b1;
        m_br      = 1'b1;
        expect_in(1);
        step();

        point(1'b1);

        // Pause during serve: ticks and misses must not move anything.
        enable = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        enable    = 1'b1;
        step();
        serve_ticks();

        // Simultaneous miss: no point, re-serve, direction kept.
        miss_left  = 1'b1;
        miss_right = 1'b1;
        m_br       = 1'b0;
        m_brs      = 1'b1;
        expect_in(1);
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        m_brs      = 1'b0;
        expect_in(1);
        step();
        serve_ticks();

        point(1'b1);
        serve_ticks();
        point(1'b1);

        // Match over at 3-1: further activity is frozen out.
        miss_left = 1'b1;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end

        clear  = 1'b1;
        enable = 1'b0;
        m_go = 0; m_w = 0; m_sd = 0; m_br = 0; m_sl = '0; m_sr = '0;
        m_brs = 1'b1;
        expect_in(1);
        step();
        clear = 1'b0;
        m_brs = 1'b0;
        expect_in(1);
        step();

        enable = 1'b1;
        m_brs  = 1'b1;
        expect_in(1);
        step();
        m_brs = 1'b0;
        expect_in(1);
        step();
        serve_ticks();
        point(1'b0);
        serve_ticks();

        // Asynchronous reset mid-rally, asserted between clock edges.
        @(posedge clock);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        m_go = 0; m_w = 0; m_sd = 0; m_br = 0; m_brs = 0; m_sl = '0; m_sr = '0;
        expect_in(0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();

        while (q.size() != 0) begin
            mon_e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event got=no change required=%h at cyc %0d", mon_e.v, mon_e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
